usb_cdc_tx_scheduler: RTL and testbench

Shares the single 8-bit IN (device-to-host) byte stream of a usb_cdc channel between several on-chip byte sources.
- Grants sources round-robin, one burst at a time.
- Optionally prefixes each burst with a one-byte source-ID header so the host can demultiplex.
- Sits between the user logic and the usb_cdc in_data/in_valid/in_ready port of one channel.
- Gated by the usb_cdc configured status.

---
 rtl/usb_cdc_tx_scheduler.sv | 168 ++++++++++++++++
 tb/tb_usb_cdc_tx_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cdc_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usb_cdc_tx_scheduler                                            |
// | Brief    : Round-robin burst scheduler sharing one usb_cdc IN byte stream  |
// |            between several byte sources, with optional source-ID header.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module usb_cdc_tx_scheduler #(
    parameter int REQUESTERS = 4,
    parameter int BURST_LEN  = 8,
    parameter int HEADER_EN  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [8*REQUESTERS-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]   req_valid_i,
    output logic [REQUESTERS-1:0]   req_ready_o,
    output logic [7:0]              in_data_o,
    output logic                    in_valid_o,
    input  logic                    in_ready_i,
    input  logic                    configured_i,
    output logic [REQUESTERS-1:0]   grant_o,
    output logic                    busy_o,
    output logic [15:0]             burst_cnt_o
);

    localparam int               c_GW       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int               c_GW1      = c_GW + 1;
    localparam logic [c_GW:0]    c_NREQ     = c_GW1'(REQUESTERS);
    localparam logic [c_GW-1:0]  c_LAST_IDX = c_GW'(REQUESTERS - 1);
    localparam logic [7:0]       c_LAST_CNT = 8'(BURST_LEN - 1);
    localparam logic [7:0]       c_HDR_BASE = 8'hA0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_GW-1:0]       r_g;
    logic [c_GW-1:0]       r_last;
    logic [7:0]            r_cnt;
    logic [REQUESTERS-1:0] r_grant;
    logic                  r_busy;
    logic [15:0]           r_burst_cnt;

    logic [c_GW:0]           w_start;
    logic [c_GW:0]           w_sum;
    logic [2*REQUESTERS-1:0] w_dbl;
    logic [REQUESTERS-1:0]   w_rot;
    logic [c_GW-1:0]         w_off;
    logic [c_GW-1:0]         w_sel;
    logic                    w_any;
    logic [7:0]              w_g_data;
    logic                    w_g_valid;
    logic                    w_xfer;
    logic                    w_end;

    // Rotate the request vector so bit 0 is the source just after the last owner.
    always_comb begin
        w_start = (r_last == c_LAST_IDX) ? '0 : ({1'b0, r_last} + c_GW1'(1));
        w_dbl   = {req_valid_i, req_valid_i};
        w_rot   = REQUESTERS'(w_dbl >> w_start);
        w_off   = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = c_GW'(i);
            end
        end
        w_any = |req_valid_i;
        w_sum = w_start + {1'b0, w_off};
        w_sel = (w_sum >= c_NREQ) ? c_GW'(w_sum - c_NREQ) : c_GW'(w_sum);
    end

    always_comb begin
        w_g_data  = '0;
        w_g_valid = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (r_g == c_GW'(i)) begin
                w_g_data  = req_data_i[8*i +: 8];
                w_g_valid = req_valid_i[i];
            end
        end
    end

    assign w_xfer = (r_state == S_DATA) && w_g_valid && in_ready_i;
    // A dropped valid only closes the burst once at least one byte has gone out.
    assign w_end  = (r_state == S_DATA) &&
                    ((w_xfer && (r_cnt == c_LAST_CNT)) || (!w_g_valid && (r_cnt != 8'd0)));

    always_comb begin
        in_valid_o  = 1'b0;
        in_data_o   = 8'h00;
        req_ready_o = '0;
        case (r_state)
            S_HDR: begin
                in_valid_o = 1'b1;
                in_data_o  = c_HDR_BASE | {4'h0, 4'(r_g)};
            end
            S_DATA: begin
                in_valid_o  = w_g_valid;
                in_data_o   = w_g_data;
                req_ready_o = r_grant & {REQUESTERS{in_ready_i}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_g         <= '0;
            r_last      <= c_LAST_IDX;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (configured_i && w_any) begin
                        r_g     <= w_sel;
                        r_grant <= REQUESTERS'(1) << w_sel;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (HEADER_EN != 0) ? S_HDR : S_DATA;
                    end
                end
                S_HDR: begin
                    if (!configured_i) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (in_ready_i) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!configured_i) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_end) begin
                        r_last      <= r_g;
                        r_burst_cnt <= r_burst_cnt + 16'd1;
                        r_grant     <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o     = r_grant;
    assign busy_o      = r_busy;
    assign burst_cnt_o = r_burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_usb_cdc_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_usb_cdc_tx_scheduler                                         |
// | Brief    : Directed self-checking bench for usb_cdc_tx_scheduler.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_usb_cdc_tx_scheduler;

    localparam int NREQ = 4;
    localparam int BL_A = 8;

    logic clk;
    logic rst;

    logic [8*NREQ-1:0] req_data_a;
    logic [NREQ-1:0]   req_valid_a;
    logic [NREQ-1:0]   req_ready_a;
    logic [7:0]        in_data_a;
    logic              in_valid_a;
    logic              in_ready_a;
    logic              configured_a;
    logic [NREQ-1:0]   grant_a;
    logic              busy_a;
    logic [15:0]       burst_cnt_a;

    logic [8*NREQ-1:0] req_data_b;
    logic [NREQ-1:0]   req_valid_b;
    logic [NREQ-1:0]   req_ready_b;
    logic [7:0]        in_data_b;
    logic              in_valid_b;
    logic              in_ready_b;
    logic              configured_b;
    logic [NREQ-1:0]   grant_b;
    logic              busy_b;
    logic [15:0]       burst_cnt_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] src_q [NREQ][$];
    logic [7:0] exp_q [$];
    int         model_last   = NREQ - 1;
    int         model_bursts = 0;
    logic       toggle_ready = 1'b0;

    logic [NREQ-1:0] prev_grant  = '0;
    logic            hdr_pending = 1'b0;
    logic            prev_stall  = 1'b0;
    logic [7:0]      prev_data   = 8'h00;

    usb_cdc_tx_scheduler #(.REQUESTERS(NREQ), .BURST_LEN(BL_A), .HEADER_EN(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(req_data_a), .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
        .in_data_o(in_data_a), .in_valid_o(in_valid_a), .in_ready_i(in_ready_a),
        .configured_i(configured_a), .grant_o(grant_a), .busy_o(busy_a),
        .burst_cnt_o(burst_cnt_a)
    );

    usb_cdc_tx_scheduler #(.REQUESTERS(NREQ), .BURST_LEN(1), .HEADER_EN(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(req_data_b), .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
        .in_data_o(in_data_b), .in_valid_o(in_valid_b), .in_ready_i(in_ready_b),
        .configured_i(configured_b), .grant_o(grant_b), .busy_o(busy_b),
        .burst_cnt_o(burst_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gdata(input logic [NREQ-1:0] g, input logic [8*NREQ-1:0] d);
        logic [7:0] r = 8'h00;
        for (int k = 0; k < NREQ; k++) if (g[k]) r = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [7:0] gidx(input logic [NREQ-1:0] g);
        logic [7:0] r = 8'h00;
        for (int k = 0; k < NREQ; k++) if (g[k]) r = 8'(k);
        return r;
    endfunction

    // Expected IN stream from the current source queues: round-robin from the
    // last owner, one header then up to BL_A bytes per grant.
    task automatic model_build();
        logic [7:0] q [NREQ][$];
        int         pending;
        for (int k = 0; k < NREQ; k++) q[k] = src_q[k];
        pending = 0;
        for (int k = 0; k < NREQ; k++) pending += q[k].size();
        while (pending != 0) begin
            int owner;
            owner = -1;
            for (int i = 1; i <= NREQ; i++) begin
                int c;
                c = (model_last + i) % NREQ;
                if (owner < 0 && q[c].size() != 0) owner = c;
            end
            exp_q.push_back(8'hA0 | 8'(owner));
            for (int b = 0; b < BL_A && q[owner].size() != 0; b++) begin
                exp_q.push_back(q[owner].pop_front());
                pending--;
            end
            model_last = owner;
            model_bursts++;
        end
    endtask

    task automatic drive_sources();
        for (int k = 0; k < NREQ; k++) begin
            if (src_q[k].size() != 0) begin
                req_valid_a[k]          = 1'b1;
                req_data_a[8*k +: 8]    = src_q[k][0];
            end else begin
                req_valid_a[k]          = 1'b0;
                req_data_a[8*k +: 8]    = 8'h00;
            end
        end
    endtask

    // One clock: note what was accepted, then advance the source queues.
    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid_a & req_ready_a;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) if (acc[k]) void'(src_q[k].pop_front());
        drive_sources();
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_a) && n < max_cycles) begin
            tick();
            in_ready_a = toggle_ready ? ~in_ready_a : 1'b1;
            n++;
        end
        check({name, "_done"}, 16'(n < max_cycles), 16'd1);
        tick();
        tick();
        check({name, "_bursts"}, burst_cnt_a, 16'(model_bursts));
        check({name, "_leftover"}, 16'(exp_q.size()), 16'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_grant  = '0;
            hdr_pending = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (grant_a != '0 && prev_grant == '0) hdr_pending = 1'b1;
            check("grant_onehot0", 16'($onehot0(grant_a)), 16'd1);
            check("busy_vs_grant", 16'(busy_a), 16'(grant_a != '0));
            if (grant_a == '0) begin
                check("idle_valid", 16'(in_valid_a), 16'd0);
                check("idle_ready", 16'(req_ready_a), 16'd0);
            end else if (hdr_pending) begin
                check("hdr_valid", 16'(in_valid_a), 16'd1);
                check("hdr_data", 16'(in_data_a), 16'(8'hA0 | gidx(grant_a)));
                check("hdr_ready", 16'(req_ready_a), 16'd0);
            end else begin
                check("data_ready", 16'(req_ready_a), 16'(grant_a & {NREQ{in_ready_a}}));
                check("data_valid", 16'(in_valid_a), 16'(|(req_valid_a & grant_a)));
                if (in_valid_a) check("data_pass", 16'(in_data_a), 16'(gdata(grant_a, req_data_a)));
            end
            if (prev_stall) begin
                check("stall_valid", 16'(in_valid_a), 16'd1);
                check("stall_data", 16'(in_data_a), 16'(prev_data));
            end
            if (in_valid_a && in_ready_a) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_extra: got 0x%0h expected no byte at %0t", in_data_a, $time);
                end else begin
                    check("stream", 16'(in_data_a), 16'(exp_q.pop_front()));
                end
                hdr_pending = 1'b0;
            end
            prev_stall = in_valid_a && !in_ready_a && configured_a;
            prev_data  = in_data_a;
            prev_grant = grant_a;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] b_exp [0:4];
        int         gcount;
        b_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};

        rst          = 1'b1;
        req_data_a   = '0;
        req_valid_a  = '0;
        in_ready_a   = 1'b1;
        configured_a = 1'b0;
        req_data_b   = {8'h40, 8'h30, 8'h20, 8'h10};
        req_valid_b  = 4'hF;
        in_ready_b   = 1'b1;
        configured_b = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 16'(grant_a), 16'd0);
        check("rst_busy", 16'(busy_a), 16'd0);
        check("rst_bcnt", burst_cnt_a, 16'd0);
        check("rst_valid", 16'(in_valid_a), 16'd0);
        check("rst_ready", 16'(req_ready_a), 16'd0);
        check("rst_grant_b", 16'(grant_b), 16'd0);
        rst = 1'b0;

        // Source 2 sends three bytes then drops valid.
        src_q[2] = '{8'h11, 8'h22, 8'h33};
        model_build();
        configured_a = 1'b1;
        drive_sources();
        check("t1_grant_c0", 16'(grant_a), 16'd0);
        tick();
        check("t1_grant_c1", 16'(grant_a), 16'b0100);
        gcount = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (grant_a == 4'b0100) gcount++;
        end
        // Header, three data cycles, and the cycle in which the dropped valid closes the burst.
        check("t1_grant_cycles", 16'(gcount), 16'd5);
        check("t1_bcnt", burst_cnt_a, 16'd1);
        check("t1_busy", 16'(busy_a), 16'd0);
        check("t1_leftover", 16'(exp_q.size()), 16'd0);

        // Sources 0 and 1 stream twenty bytes each.
        for (int i = 0; i < 20; i++) begin
            src_q[0].push_back(8'h10 + 8'(i));
            src_q[1].push_back(8'h50 + 8'(i));
        end
        model_build();
        check("t2_model_len", 16'(exp_q.size()), 16'd46);
        check("t2_model_h0", 16'(exp_q[0]), 16'h00A0);
        check("t2_model_h1", 16'(exp_q[9]), 16'h00A1);
        drive_sources();
        drain("t2", 400);
        check("t2_bcnt", burst_cnt_a, 16'd7);

        // Source 3 with in_ready toggling every cycle.
        for (int i = 0; i < 6; i++) src_q[3].push_back(8'hB0 + 8'(i));
        model_build();
        drive_sources();
        toggle_ready = 1'b1;
        in_ready_a   = 1'b1;
        drain("t3", 400);
        toggle_ready = 1'b0;
        in_ready_a   = 1'b1;

        // configured_i drops while source 0 presents its fourth data byte.
        for (int i = 0; i < 10; i++) src_q[0].push_back(8'hC0 + 8'(i));
        src_q[2] = '{8'hE0, 8'hE1};
        exp_q = '{8'hA0, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
        drive_sources();
        for (int n = 0; n < 50 && src_q[0].size() != 7; n++) tick();
        check("t4_reached", 16'(src_q[0].size()), 16'd7);
        configured_a = 1'b0;
        tick();
        check("t4_abort_valid", 16'(in_valid_a), 16'd0);
        check("t4_abort_grant", 16'(grant_a), 16'd0);
        check("t4_abort_busy", 16'(busy_a), 16'd0);
        check("t4_abort_bcnt", burst_cnt_a, 16'd8);
        configured_a = 1'b1;
        model_build();
        drain("t4", 400);
        check("t4_bcnt", burst_cnt_a, 16'd10);

        // No-header, single-byte bursts with every source requesting.
        @(posedge clk);
        #1;
        configured_b = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 10) begin
                check("b_valid", 16'(in_valid_b), 16'((c % 2) == 1));
                if ((c % 2) == 1) begin
                    check("b_data", 16'(in_data_b), 16'(b_exp[c/2]));
                    check("b_grant", 16'(grant_b), 16'(4'b0001 << ((c / 2) % 4)));
                end
            end else begin
                check("b_noconfig_grant", 16'(grant_b), 16'd0);
            end
            @(posedge clk);
            #1;
            if (c == 9) configured_b = 1'b0;
        end
        check("b_bcnt", burst_cnt_b, 16'd5);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 8; i++) src_q[1].push_back(8'h70 + 8'(i));
        model_build();
        drive_sources();
        repeat (4) tick();
        check("t6_busy_pre", 16'(busy_a), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 16'(in_valid_a), 16'd0);
        check("t6_rst_grant", 16'(grant_a), 16'd0);
        check("t6_rst_busy", 16'(busy_a), 16'd0);
        check("t6_rst_bcnt", burst_cnt_a, 16'd0);
        check("t6_rst_ready", 16'(req_ready_a), 16'd0);
        check("t6_rst_data", 16'(in_data_a), 16'd0);
        for (int k = 0; k < NREQ; k++) src_q[k].delete();
        exp_q.delete();
        model_last   = NREQ - 1;
        model_bursts = 0;
        drive_sources();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        src_q[3] = '{8'h33, 8'h34};
        src_q[0] = '{8'h01, 8'h02};
        model_build();
        check("t6_model_h3", 16'(exp_q[3]), 16'h00A3);
        drive_sources();
        drain("t6", 200);
        check("t6_bcnt", burst_cnt_a, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
